// File: rtl/nlm_cu_pkg.sv
// Shared types and constants for the NLM coefficient-unit controller.
package nlm_cu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } cu_state_e;

  localparam int NLM_CU_OP_NUM = 6;
  localparam int NLM_CU_ALU_SZ = 16;

endpackage

// File: rtl/nlm_cu_shadow_bank.sv
// Staging/active coefficient bank: results land in staging, move to active on frame start.
module nlm_cu_shadow_bank
  import nlm_cu_pkg::*;
#(
  parameter int ALU_SZ = NLM_CU_ALU_SZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic              apply,
  input  logic [ALU_SZ-1:0] cap_op [NLM_CU_OP_NUM],
  output logic [ALU_SZ-1:0] act_op [NLM_CU_OP_NUM],
  output logic              upd
);

  logic [ALU_SZ-1:0] stg_op [NLM_CU_OP_NUM];
  logic              stg_vld;
  logic              do_apply;

  assign do_apply = apply && stg_vld;

  // Apply reads the pre-capture staging contents; a same-cycle capture re-arms stg_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLM_CU_OP_NUM; i++) begin
        stg_op[i] <= '0;
        act_op[i] <= '0;
      end
      stg_vld <= 1'b0;
      upd     <= 1'b0;
    end else begin
      if (do_apply) begin
        for (int i = 0; i < NLM_CU_OP_NUM; i++) begin
          act_op[i] <= stg_op[i];
        end
        upd <= 1'b1;
      end else begin
        upd <= 1'b0;
      end

      if (cap) begin
        for (int i = 0; i < NLM_CU_OP_NUM; i++) begin
          stg_op[i] <= cap_op[i];
        end
        stg_vld <= 1'b1;
      end else if (do_apply) begin
        stg_vld <= 1'b0;
      end else begin
        stg_vld <= stg_vld;
      end
    end
  end

endmodule

// File: rtl/nlm_cu_ctrl.sv
// Task sequencer with timeout supervision plus frame-synchronous result shadow bank.
// Optional: define NLM_CU_CTRL_AUTO_TRG_EN to also request a task on every frame start.
module nlm_cu_ctrl
  import nlm_cu_pkg::*;
#(
  parameter int ALU_SZ   = NLM_CU_ALU_SZ,
  parameter int TOUT_CYC = 1023,
  parameter int TOUT_WID = $clog2(TOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frm_start,
  input  logic              i_parm_upd,
  output logic              o_cu_tsk_trg,
  input  logic              i_cu_tsk_end,
  input  logic [ALU_SZ-1:0] i_cu_op0,
  input  logic [ALU_SZ-1:0] i_cu_op1,
  input  logic [ALU_SZ-1:0] i_cu_op2,
  input  logic [ALU_SZ-1:0] i_cu_op3,
  input  logic [ALU_SZ-1:0] i_cu_op4,
  input  logic [ALU_SZ-1:0] i_cu_op5,
  output logic [ALU_SZ-1:0] o_nlm_op0,
  output logic [ALU_SZ-1:0] o_nlm_op1,
  output logic [ALU_SZ-1:0] o_nlm_op2,
  output logic [ALU_SZ-1:0] o_nlm_op3,
  output logic [ALU_SZ-1:0] o_nlm_op4,
  output logic [ALU_SZ-1:0] o_nlm_op5,
  output logic              o_nlm_op_upd,
  output logic              o_cu_busy,
  output logic              o_cu_tout
);

  localparam logic [TOUT_WID-1:0] TOUT_LAST = TOUT_WID'(TOUT_CYC - 1);
  localparam logic [TOUT_WID-1:0] CNT_ONE   = TOUT_WID'(1);

  cu_state_e         state;
  logic [TOUT_WID-1:0] cnt;
  logic              pend;
  logic              pend_set;
  logic              cap;
  logic [ALU_SZ-1:0] cap_op [NLM_CU_OP_NUM];
  logic [ALU_SZ-1:0] act_op [NLM_CU_OP_NUM];

`ifdef NLM_CU_CTRL_AUTO_TRG_EN
  assign pend_set = i_parm_upd || i_frm_start;
`else
  assign pend_set = i_parm_upd;
`endif

  assign cap = (state == WAIT) && i_cu_tsk_end;

  // Pending request and task FSM; cnt holds cycles elapsed since the trigger pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend         <= 1'b0;
      o_cu_tsk_trg <= 1'b0;
      o_cu_busy    <= 1'b0;
      o_cu_tout    <= 1'b0;
    end else begin
      if (pend_set) begin
        pend <= 1'b1;
      end else if ((state == IDLE) && pend) begin
        pend <= 1'b0;
      end else begin
        pend <= pend;
      end

      case (state)
        IDLE: begin
          if (pend) begin
            state        <= TRIG;
            o_cu_tsk_trg <= 1'b1;
            o_cu_busy    <= 1'b1;
            cnt          <= '0;
          end else begin
            o_cu_tsk_trg <= 1'b0;
          end
        end
        TRIG: begin
          o_cu_tsk_trg <= 1'b0;
          cnt          <= CNT_ONE;
          state        <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_ONE;
          if (i_cu_tsk_end) begin
            state     <= IDLE;
            o_cu_busy <= 1'b0;
          end else if (cnt == TOUT_LAST) begin
            state     <= IDLE;
            o_cu_busy <= 1'b0;
            o_cu_tout <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state        <= IDLE;
          o_cu_tsk_trg <= 1'b0;
          o_cu_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign cap_op[0] = i_cu_op0;
  assign cap_op[1] = i_cu_op1;
  assign cap_op[2] = i_cu_op2;
  assign cap_op[3] = i_cu_op3;
  assign cap_op[4] = i_cu_op4;
  assign cap_op[5] = i_cu_op5;

  nlm_cu_shadow_bank #(
    .ALU_SZ (ALU_SZ)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .cap    (cap),
    .apply  (i_frm_start),
    .cap_op (cap_op),
    .act_op (act_op),
    .upd    (o_nlm_op_upd)
  );

  assign o_nlm_op0 = act_op[0];
  assign o_nlm_op1 = act_op[1];
  assign o_nlm_op2 = act_op[2];
  assign o_nlm_op3 = act_op[3];
  assign o_nlm_op4 = act_op[4];
  assign o_nlm_op5 = act_op[5];

endmodule

// File: tb/tb_nlm_cu_ctrl.sv
// Directed self-checking bench for nlm_cu_ctrl (default TOUT_CYC = 1023).
module tb_nlm_cu_ctrl;

  localparam int TOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_frm_start = 1'b0;
  logic        i_parm_upd = 1'b0;
  logic        i_cu_tsk_end = 1'b0;
  logic        o_cu_tsk_trg;
  logic [15:0] i_cu_op0 = 16'h0, i_cu_op1 = 16'h0, i_cu_op2 = 16'h0;
  logic [15:0] i_cu_op3 = 16'h0, i_cu_op4 = 16'h0, i_cu_op5 = 16'h0;
  logic [15:0] o_nlm_op0, o_nlm_op1, o_nlm_op2, o_nlm_op3, o_nlm_op4, o_nlm_op5;
  logic        o_nlm_op_upd;
  logic        o_cu_busy;
  logic        o_cu_tout;

  int vectors = 0;
  int miscompares = 0;
  int trg_cnt;

  always #5 clk = ~clk;

  nlm_cu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_frm_start  (i_frm_start),
    .i_parm_upd   (i_parm_upd),
    .o_cu_tsk_trg (o_cu_tsk_trg),
    .i_cu_tsk_end (i_cu_tsk_end),
    .i_cu_op0     (i_cu_op0),
    .i_cu_op1     (i_cu_op1),
    .i_cu_op2     (i_cu_op2),
    .i_cu_op3     (i_cu_op3),
    .i_cu_op4     (i_cu_op4),
    .i_cu_op5     (i_cu_op5),
    .o_nlm_op0    (o_nlm_op0),
    .o_nlm_op1    (o_nlm_op1),
    .o_nlm_op2    (o_nlm_op2),
    .o_nlm_op3    (o_nlm_op3),
    .o_nlm_op4    (o_nlm_op4),
    .o_nlm_op5    (o_nlm_op5),
    .o_nlm_op_upd (o_nlm_op_upd),
    .o_cu_busy    (o_cu_busy),
    .o_cu_tout    (o_cu_tout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3,
                            input logic [15:0] e4, input logic [15:0] e5);
    check({tag, "_op0"}, {16'h0, o_nlm_op0}, {16'h0, e0});
    check({tag, "_op1"}, {16'h0, o_nlm_op1}, {16'h0, e1});
    check({tag, "_op2"}, {16'h0, o_nlm_op2}, {16'h0, e2});
    check({tag, "_op3"}, {16'h0, o_nlm_op3}, {16'h0, e3});
    check({tag, "_op4"}, {16'h0, o_nlm_op4}, {16'h0, e4});
    check({tag, "_op5"}, {16'h0, o_nlm_op5}, {16'h0, e5});
  endtask

  task automatic set_ops(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                         input logic [15:0] v3, input logic [15:0] v4, input logic [15:0] v5);
    i_cu_op0 = v0; i_cu_op1 = v1; i_cu_op2 = v2;
    i_cu_op3 = v3; i_cu_op4 = v4; i_cu_op5 = v5;
  endtask

  // Pulse i_parm_upd, step to the trigger cycle and then into WAIT.
  task automatic start_task(input string tag);
    i_parm_upd = 1'b1;
    tick();
    i_parm_upd = 1'b0;
    check({tag, "_trg_n1"}, {31'h0, o_cu_tsk_trg}, 32'h0);
    tick();
    check({tag, "_trg_n2"}, {31'h0, o_cu_tsk_trg}, 32'h1);
    check({tag, "_busy_trg"}, {31'h0, o_cu_busy}, 32'h1);
    tick();
    check({tag, "_trg_n3"}, {31'h0, o_cu_tsk_trg}, 32'h0);
    check({tag, "_busy_wait"}, {31'h0, o_cu_busy}, 32'h1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_trg", {31'h0, o_cu_tsk_trg}, 32'h0);
    check("rst_busy", {31'h0, o_cu_busy}, 32'h0);
    check("rst_tout", {31'h0, o_cu_tout}, 32'h0);
    check("rst_upd", {31'h0, o_nlm_op_upd}, 32'h0);
    check_bank("rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    tick();

`ifndef NLM_CU_CTRL_AUTO_TRG_EN
    // 1: trigger, capture, hold until frame start, apply
    start_task("t1");
    set_ops(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0F0F, 16'hF0F0);
    for (int i = 0; i < 5; i++) tick();
    i_cu_tsk_end = 1'b1;
    tick();
    i_cu_tsk_end = 1'b0;
    set_ops(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    check("t1_busy_end", {31'h0, o_cu_busy}, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check_bank("t1_hold", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("t1_trg_idle", {31'h0, o_cu_tsk_trg}, 32'h0);
    i_frm_start = 1'b1;
    tick();
    i_frm_start = 1'b0;
    check_bank("t1_apply", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0F0F, 16'hF0F0);
    check("t1_upd", {31'h0, o_nlm_op_upd}, 32'h1);
    tick();
    check("t1_upd_off", {31'h0, o_nlm_op_upd}, 32'h0);

    // 2: timeout exactly TOUT cycles after the trigger pulse
    start_task("t2");
    for (int i = 0; i < TOUT - 2; i++) tick();
    check("t2_tout_early", {31'h0, o_cu_tout}, 32'h0);
    check("t2_busy_early", {31'h0, o_cu_busy}, 32'h1);
    tick();
    check("t2_tout", {31'h0, o_cu_tout}, 32'h1);
    check("t2_busy_fall", {31'h0, o_cu_busy}, 32'h0);
    i_cu_tsk_end = 1'b1;
    tick();
    i_cu_tsk_end = 1'b0;
    i_frm_start = 1'b1;
    tick();
    i_frm_start = 1'b0;
    check("t2_upd", {31'h0, o_nlm_op_upd}, 32'h0);
    check_bank("t2_keep", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0F0F, 16'hF0F0);

    // 3: parm update during WAIT gives exactly one re-trigger; latest capture wins
    start_task("t3");
    i_parm_upd = 1'b1;
    tick();
    i_parm_upd = 1'b0;
    set_ops(16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005);
    i_cu_tsk_end = 1'b1;
    tick();
    i_cu_tsk_end = 1'b0;
    check("t3_trg_e1", {31'h0, o_cu_tsk_trg}, 32'h0);
    check("t3_busy_e1", {31'h0, o_cu_busy}, 32'h0);
    tick();
    check("t3_retrg", {31'h0, o_cu_tsk_trg}, 32'h1);
    tick();
    check("t3_retrg_off", {31'h0, o_cu_tsk_trg}, 32'h0);
    set_ops(16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005);
    i_cu_tsk_end = 1'b1;
    tick();
    i_cu_tsk_end = 1'b0;
    trg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_cu_tsk_trg) trg_cnt++;
    end
    check("t3_no_extra_trg", trg_cnt, 32'h0);
    i_frm_start = 1'b1;
    tick();
    i_frm_start = 1'b0;
    check("t3_upd", {31'h0, o_nlm_op_upd}, 32'h1);
    check_bank("t3_apply", 16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005);
    check("t3_tout_sticky", {31'h0, o_cu_tout}, 32'h1);

    // 4: capture and frame start together with empty staging -> deferred apply
    start_task("t4");
    set_ops(16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h3004, 16'h3005);
    i_cu_tsk_end = 1'b1;
    i_frm_start = 1'b1;
    tick();
    i_cu_tsk_end = 1'b0;
    i_frm_start = 1'b0;
    check("t4_no_upd", {31'h0, o_nlm_op_upd}, 32'h0);
    check("t4_old_op0", {16'h0, o_nlm_op0}, 32'h2000);
    tick();
    i_frm_start = 1'b1;
    tick();
    i_frm_start = 1'b0;
    check("t4_upd", {31'h0, o_nlm_op_upd}, 32'h1);
    check_bank("t4_apply", 16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h3004, 16'h3005);

    // 5: reset mid-WAIT, late task end ignored
    start_task("t5");
    set_ops(16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h4444);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", {31'h0, o_cu_busy}, 32'h0);
    check("t5_tout", {31'h0, o_cu_tout}, 32'h0);
    check_bank("t5_rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    tick();
    i_cu_tsk_end = 1'b1;
    tick();
    i_cu_tsk_end = 1'b0;
    trg_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_cu_tsk_trg) trg_cnt++;
    end
    check("t5_no_trg", trg_cnt, 32'h0);
    check("t5_busy_late", {31'h0, o_cu_busy}, 32'h0);
    i_frm_start = 1'b1;
    tick();
    i_frm_start = 1'b0;
    check("t5_no_upd", {31'h0, o_nlm_op_upd}, 32'h0);
    check("t5_op0", {16'h0, o_nlm_op0}, 32'h0);
`endif

    // 6: frame starts alone trigger tasks only in the auto-trigger build
    trg_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      i_frm_start  = (i == 0 || i == 100);
      i_cu_tsk_end = (i == 20 || i == 120);
      tick();
      if (o_cu_tsk_trg) trg_cnt++;
    end
    i_frm_start  = 1'b0;
    i_cu_tsk_end = 1'b0;
`ifdef NLM_CU_CTRL_AUTO_TRG_EN
    check("t6_auto_trg", trg_cnt, 32'h2);
`else
    check("t6_no_auto_trg", trg_cnt, 32'h0);
`endif
    check("t6_busy_idle", {31'h0, o_cu_busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
